// File: rtl/bin2bcd_param.sv
// rtl/bin2bcd_param.sv - sequential shift-and-add-3 binary to BCD converter
//
// Purpose: converts a BIN_W-bit binary operand (optionally two's complement)
//          into DIGITS packed BCD digits, one operand bit per clock, with
//          sign, overflow and significant-digit count for display blanking.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   conversion request, honoured only while ready
//   bin        in   binary operand, captured on the accepting edge
//   ready      out  high while idle
//   done_tick  out  one-cycle pulse marking a valid result
//   bcd        out  result digits, [3:0] = units
//   sign       out  operand was negative (signed mode only)
//   overflow   out  value did not fit in DIGITS digits
//   ndig       out  number of significant digits, 1..DIGITS
module bin2bcd_param #(
   parameter  int BIN_W  = 16,
   parameter  int DIGITS = 5,
   parameter  int SIGNED = 0,
   localparam int NW     = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  ready,
   output logic                  done_tick,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign,
   output logic                  overflow,
   output logic [NW-1:0]         ndig
);

   localparam int CW = $clog2(BIN_W + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OP   = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [BIN_W-1:0]    r_sh;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] r_bcd;
   logic                r_sign;
   logic                r_ovf;
   logic [NW-1:0]       r_ndig;
   logic                r_done;

   logic                w_neg;
   logic [BIN_W-1:0]    w_mag;
   logic [4*DIGITS-1:0] w_adj;
   logic [NW-1:0]       w_ndig;

   // BIN_W-bit negate: the most negative value wraps to 2^(BIN_W-1),
   // which is exactly its magnitude when read as unsigned.
   assign w_neg = (SIGNED != 0) && bin[BIN_W-1];
   assign w_mag = w_neg ? (~bin + BIN_W'(1)) : bin;

   always_comb begin
      w_adj = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] > 4'd4)
            w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
         else
            w_adj[4*d +: 4] = r_bcd[4*d +: 4];
      end
   end

   // Highest non-zero digit sets the count; an overflowed value always
   // occupies every digit even if the retained digits happen to be zero.
   always_comb begin
      w_ndig = NW'(1);
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] != 4'd0)
            w_ndig = NW'(d + 1);
      end
      if (r_ovf)
         w_ndig = NW'(DIGITS);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
         r_sign  <= 1'b0;
         r_ovf   <= 1'b0;
         r_ndig  <= NW'(1);
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_bcd   <= '0;
                  r_ovf   <= 1'b0;
                  r_sh    <= w_mag;
                  r_sign  <= w_neg;
                  r_cnt   <= CW'(BIN_W);
                  r_state <= S_OP;
               end
            end
            S_OP: begin
               // Adjusted digits and operand shift left as one long register;
               // the bit falling off the top digit can only mean overflow.
               r_bcd <= {w_adj[4*DIGITS-2:0], r_sh[BIN_W-1]};
               r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
               r_ovf <= r_ovf | w_adj[4*DIGITS-1];
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1))
                  r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_ndig  <= w_ndig;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready     = (r_state == S_IDLE);
   assign done_tick = r_done;
   assign bcd       = r_bcd;
   assign sign      = r_sign;
   assign overflow  = r_ovf;
   assign ndig      = r_ndig;

endmodule

// File: tb/tb_bin2bcd_param.sv
// tb/tb_bin2bcd_param.sv - directed self-checking bench for bin2bcd_param
module tb_bin2bcd_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_v [3];
   logic [15:0] bin_v   [3];
   logic        ready_v [3];
   logic        done_v  [3];
   logic        sign_v  [3];
   logic        ovf_v   [3];
   logic [2:0]  ndig_v  [3];
   logic [19:0] bcd0;
   logic [15:0] bcd1;
   logic [19:0] bcd2;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin2bcd_param #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_def (
      .clk(clk), .reset_n(rst_n), .start(start_v[0]), .bin(bin_v[0]),
      .ready(ready_v[0]), .done_tick(done_v[0]), .bcd(bcd0),
      .sign(sign_v[0]), .overflow(ovf_v[0]), .ndig(ndig_v[0]));

   bin2bcd_param #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_d4 (
      .clk(clk), .reset_n(rst_n), .start(start_v[1]), .bin(bin_v[1]),
      .ready(ready_v[1]), .done_tick(done_v[1]), .bcd(bcd1),
      .sign(sign_v[1]), .overflow(ovf_v[1]), .ndig(ndig_v[1]));

   bin2bcd_param #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_sgn (
      .clk(clk), .reset_n(rst_n), .start(start_v[2]), .bin(bin_v[2]),
      .ready(ready_v[2]), .done_tick(done_v[2]), .bcd(bcd2),
      .sign(sign_v[2]), .overflow(ovf_v[2]), .ndig(ndig_v[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one accepting edge, then wait (bounded) for done_tick.
   // lat counts edges after the accepting edge until done_tick is seen.
   task automatic run(input int inst, input logic [15:0] b, output int lat);
      bin_v[inst]   = b;
      start_v[inst] = 1'b1;
      @(posedge clk); #1;
      start_v[inst] = 1'b0;
      lat = 0;
      while (!done_v[inst] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bad_ready;
      int ndone;
      int t [3];
      logic [19:0] cap;

      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         bin_v[i]   = '0;
      end

      // reset state
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_bcd",   bcd0, 20'h0);
      chk("rst_ndig",  ndig_v[0], 3'd1);
      chk("rst_done",  done_v[0], 1'b0);
      chk("rst_ovf",   ovf_v[0], 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", ready_v[0], 1'b1);

      // 65535: latency, ready low through the conversion, single pulse
      bin_v[0]   = 16'd65535;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      chk("busy_ready", ready_v[0], 1'b0);
      lat = 0;
      bad_ready = 0;
      while (!done_v[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat < 17 && ready_v[0]) bad_ready++;
      end
      chk("lat_65535",   lat, 17);
      chk("ready_in_op", bad_ready, 0);
      chk("bcd_65535",   bcd0, 20'h65535);
      chk("ndig_65535",  ndig_v[0], 3'd5);
      chk("ovf_65535",   ovf_v[0], 1'b0);
      chk("sign_65535",  sign_v[0], 1'b0);
      chk("ready_done",  ready_v[0], 1'b1);
      @(posedge clk); #1;
      chk("done_width",  done_v[0], 1'b0);

      run(0, 16'd0, lat);
      chk("lat_0",  lat, 17);
      chk("bcd_0",  bcd0, 20'h0);
      chk("ndig_0", ndig_v[0], 3'd1);
      chk("ovf_0",  ovf_v[0], 1'b0);
      run(0, 16'd907, lat);
      chk("bcd_907",  bcd0, 20'h00907);
      chk("ndig_907", ndig_v[0], 3'd3);

      // four-digit instance: overflow keeps value mod 10^4
      run(1, 16'd12345, lat);
      chk("lat_d4",    lat, 17);
      chk("ovf_12345", ovf_v[1], 1'b1);
      chk("bcd_12345", bcd1, 16'h2345);
      chk("ndig_12345", ndig_v[1], 3'd4);
      run(1, 16'd9999, lat);
      chk("ovf_9999", ovf_v[1], 1'b0);
      chk("bcd_9999", bcd1, 16'h9999);

      // signed instance
      run(2, 16'h8000, lat);
      chk("sign_8000", sign_v[2], 1'b1);
      chk("bcd_8000",  bcd2, 20'h32768);
      chk("ovf_8000",  ovf_v[2], 1'b0);
      run(2, 16'hFFFF, lat);
      chk("sign_ffff", sign_v[2], 1'b1);
      chk("bcd_ffff",  bcd2, 20'h00001);
      chk("ndig_ffff", ndig_v[2], 3'd1);
      run(2, 16'h7FFF, lat);
      chk("sign_7fff", sign_v[2], 1'b0);
      chk("bcd_7fff",  bcd2, 20'h32767);

      // start/bin wiggled during OP are ignored
      bin_v[0]   = 16'd1234;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      ndone = 0;
      cap   = '0;
      for (int i = 0; i < 30; i++) begin
         if (i < 10) begin
            start_v[0] = i[0];
            bin_v[0]   = (i[0]) ? 16'd9999 : 16'd4321;
         end else begin
            start_v[0] = 1'b0;
         end
         @(posedge clk); #1;
         if (done_v[0]) begin
            ndone++;
            cap = bcd0;
         end
      end
      chk("ign_ndone", ndone, 1);
      chk("ign_bcd",   cap, 20'h01234);

      // start held high: back-to-back conversions every BIN_W+2 cycles
      bin_v[0]   = 16'd500;
      start_v[0] = 1'b1;
      ndone = 0;
      for (int i = 0; i < 100 && ndone < 3; i++) begin
         @(posedge clk); #1;
         if (done_v[0]) begin
            t[ndone] = cyc;
            ndone++;
         end
      end
      start_v[0] = 1'b0;
      chk("hold_ndone", ndone, 3);
      if (ndone == 3) begin
         chk("hold_gap1", t[1] - t[0], 18);
         chk("hold_gap2", t[2] - t[1], 18);
      end
      chk("hold_bcd", bcd0, 20'h00500);

      // reset in the middle of OP aborts silently
      @(posedge clk); #1;
      bin_v[0]   = 16'd65535;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_bcd",   bcd0, 20'h0);
      chk("abort_ndig",  ndig_v[0], 3'd1);
      chk("abort_ovf",   ovf_v[0], 1'b0);
      chk("abort_sign",  sign_v[0], 1'b0);
      chk("abort_done",  done_v[0], 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      chk("abort_ready", ready_v[0], 1'b1);
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done_v[0]) ndone++;
      end
      chk("abort_nodone", ndone, 0);
      run(0, 16'd42, lat);
      chk("lat_42",  lat, 17);
      chk("bcd_42",  bcd0, 20'h00042);
      chk("ndig_42", ndig_v[0], 3'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bin2bcd_param.md
Name: bin2bcd_param

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Generalised in input width and digit count.
- Adds an optional signed (two's-complement) mode, overflow detection and a significant-digit count for leading-zero blanking.
- Sits between arithmetic datapaths and display drivers (seven-segment mux, UART text formatter), using a ready/start/done_tick handshake.

Parameters:
- BIN_W, 16, binary input width (2..32).
- DIGITS, 5, number of BCD output digits (1..10).
- SIGNED, 0, 1 = treat bin as two's complement and convert its magnitude; 0 = unsigned.
- NW, $clog2(DIGITS+1), width of ndig (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled only in IDLE.
- bin  in  BIN_W  binary operand, captured on the accepting edge.
- ready  out  1  high while in IDLE.
- done_tick  out  1  one-cycle pulse, result valid.
- bcd  out  4*DIGITS  result digits; [3:0] = units, [4*DIGITS-1:4*DIGITS-4] = most significant.
- sign  out  1  1 = negative operand (always 0 when SIGNED=0).
- overflow  out  1  1 = value needs more than DIGITS digits.
- ndig  out  NW  number of significant digits (1..DIGITS); 1 for zero.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE. bcd=0, sign=0, overflow=0, ndig=1, done_tick=0, shift register=0, counter=0. ready=1 after release.
- States: IDLE, OP, DONE. Any unused encoding -> IDLE.
- IDLE:
  - ready=1.
  - On start=1 at an edge: clear digits and overflow; load shift register with |bin| (SIGNED=1) or bin; load sign=bin[BIN_W-1] & SIGNED; counter=BIN_W; -> OP.
  - Magnitude uses a BIN_W-bit unsigned negate, so -2^(BIN_W-1) converts to 2^(BIN_W-1) correctly.
- OP, one bit per clock:
  - Each digit >4 gets +3 (4-bit, no carry out).
  - Then shift {digits, shift register} left by 1; the MSB of the shift register enters the units digit.
  - The bit leaving the top digit (its adjusted bit 3) is ORed into overflow (sticky).
  - Counter decrements; when the decremented value is 0 -> DONE.
  - Exactly BIN_W cycles are spent in OP.
- DONE: done_tick=1 for one cycle; ndig registered from the final digits (index of highest non-zero digit +1, minimum 1); -> IDLE.
- Latency: done_tick is high in the cycle after the (BIN_W+1)-th rising edge following the start-sampling edge, counting the sampling edge as edge 0. Accept-to-accept throughput is BIN_W+2 cycles.
- Outputs bcd, sign, overflow and ndig:
  - Hold their final value from the DONE cycle until the next accepted start.
  - During OP they show intermediate values and are not valid.
- On overflow, bcd holds the low DIGITS decimal digits of the value (value mod 10^DIGITS) and ndig=DIGITS.
- start during OP or DONE is ignored (not queued). bin changes after the accepting edge have no effect.
- start held high continuously: a new conversion begins on the first IDLE edge after each DONE.
- Reset asserted mid-OP or in DONE: immediate return to reset values. No done_tick is produced for the aborted conversion.
- All arithmetic is unsigned 4-bit per digit; no combinational path from start to done_tick.

Test Plan:
- Default params, bin=16'd65535, start pulse -> done_tick exactly as specified in Latency (edge 17 relative to the accepting edge); bcd=20'h65535, ndig=5, overflow=0, sign=0; ready low from the accepting edge until IDLE.
- Default params, bin=0 -> bcd=0, ndig=1, overflow=0. Then bin=16'd907 -> bcd=20'h00907, ndig=3.
- BIN_W=16, DIGITS=4: bin=16'd12345 -> overflow=1, bcd=16'h2345, ndig=4. Then bin=16'd9999 -> overflow=0, bcd=16'h9999.
- SIGNED=1, BIN_W=16, DIGITS=5:
  - bin=16'h8000 -> sign=1, bcd=20'h32768.
  - bin=16'hFFFF -> sign=1, bcd=20'h00001, ndig=1.
  - bin=16'h7FFF -> sign=0, bcd=20'h32767.
- Protocol checks:
  - Toggle start and bin during OP -> result matches the originally captured operand, and exactly one done_tick.
  - Hold start=1 for 3 conversions -> done_ticks spaced BIN_W+2 cycles apart.
- Reset mid-conversion: assert reset_n=0 at OP cycle 5 for 2 cycles -> all outputs at reset values, ready=1 after release, no done_tick. A subsequent bin=16'd42 converts to bcd=20'h00042.
